// File: rtl/hack_run_controller.sv
// Run/halt/step sequencer for the Hack core: divides clk_in into a CPU strobe and debounces the board button.
// Latency: btn->debounced level 2+DEBOUNCE_CYCLES cycles; button events change state on the next edge. There is no backpressure.
module hack_run_controller #(
  parameter int CLK_DIV           = 4,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 100000000,
  parameter int RESET_TICKS       = 16,
  parameter int START_RUN         = 1
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        btn,
  output logic        cpu_ce,
  output logic        cpu_reset,
  output logic        led,
  output logic [15:0] cycle_count
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LP_W  = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int RT_W  = $clog2(RESET_TICKS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LP_W-1:0]  LP_MAX   = LP_W'(LONG_PRESS_CYCLES);
  localparam logic [RT_W-1:0]  RT_LAST  = RT_W'(RESET_TICKS - 1);

  typedef enum logic [1:0] {
    S_RESET_HOLD = 2'd0,
    S_RUN        = 2'd1,
    S_HALT       = 2'd2,
    S_STEP       = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              db_q, db_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [LP_W-1:0]   press_cnt_q, press_cnt_d;
  logic              long_fired_q, long_fired_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [RT_W-1:0]   rt_cnt_q, rt_cnt_d;
  logic [15:0]       cc_q, cc_d;

  logic tick;
  logic db_flip;
  logic long_evt;
  logic short_evt;

  always_comb begin
    sync1_d      = btn;
    sync2_d      = sync1_q;
    db_d         = db_q;
    db_cnt_d     = db_cnt_q;
    press_cnt_d  = press_cnt_q;
    long_fired_d = long_fired_q;
    div_d        = div_q;
    rt_cnt_d     = rt_cnt_q;
    state_d      = state_q;
    cc_d         = cc_q;
    db_flip      = 1'b0;

    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;

    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_flip  = 1'b1;
        db_d     = sync2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end else begin
      db_cnt_d = '0;
    end

    // A press that reaches the long threshold on its release cycle counts as long only.
    long_evt  = !db_q && (press_cnt_q == LP_MAX) && !long_fired_q;
    short_evt = !db_q && db_flip && !long_fired_q && (press_cnt_q != LP_MAX);

    if (db_q || db_flip) begin
      press_cnt_d  = '0;
      long_fired_d = 1'b0;
    end else begin
      if (press_cnt_q != LP_MAX) begin
        press_cnt_d = press_cnt_q + 1'b1;
      end
      if (long_evt) begin
        long_fired_d = 1'b1;
      end
    end

    case (state_q)
      S_RESET_HOLD: begin
        if (tick) begin
          if (rt_cnt_q == RT_LAST) begin
            rt_cnt_d = '0;
            state_d  = (START_RUN != 0) ? S_RUN : S_HALT;
          end else begin
            rt_cnt_d = rt_cnt_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (long_evt) begin
          state_d = S_RESET_HOLD;
        end else if (short_evt) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (long_evt) begin
          state_d = S_RUN;
        end else if (short_evt) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (tick) begin
          state_d = S_HALT;
        end
      end
      default: state_d = S_RESET_HOLD;
    endcase

    cpu_ce    = tick && ((state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_RESET_HOLD));
    cpu_reset = (state_q == S_RESET_HOLD);
    led       = (state_q == S_RUN);

    if ((state_d == S_RESET_HOLD) && (state_q != S_RESET_HOLD)) begin
      cc_d = '0;
    end else if (cpu_ce && (state_q != S_RESET_HOLD)) begin
      cc_d = cc_q + 16'd1;
    end
  end

  assign cycle_count = cc_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= S_RESET_HOLD;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      db_q         <= 1'b1;
      db_cnt_q     <= '0;
      press_cnt_q  <= '0;
      long_fired_q <= 1'b0;
      div_q        <= '0;
      rt_cnt_q     <= '0;
      cc_q         <= '0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      db_q         <= db_d;
      db_cnt_q     <= db_cnt_d;
      press_cnt_q  <= press_cnt_d;
      long_fired_q <= long_fired_d;
      div_q        <= div_d;
      rt_cnt_q     <= rt_cnt_d;
      cc_q         <= cc_d;
    end
  end

endmodule
